// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results and runs one outstanding
// load/store at a time on the data-memory port, with an ack timeout.
module mem_stage #(
    parameter int REG_AW  = 4,
    parameter int TIMEOUT = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rd_we,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] alu_op_out,
    output logic [DATA_W-1:0] ld_op_out,
    output logic              wr_mux_sel_out_sync,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_we,
    output logic              wb_valid,
    output logic              mem_err
);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [7:0]        cnt;
    logic [REG_AW-1:0] rd_p0;
    logic              rd_we_p0;
    logic              accept;
    logic              is_mem;
    logic              timeout_hit;

    // Gated by rst_n so every output reads 0 while reset is held.
    assign ex_ready    = rst_n && (state == IDLE);
    assign accept      = ex_valid && ex_ready;
    assign is_mem      = ex_is_load || ex_is_store;
    assign timeout_hit = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && is_mem)
                    state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (dmem_ack || timeout_hit)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            rd_p0               <= '0;
            rd_we_p0            <= 1'b0;
            dmem_req            <= 1'b0;
            dmem_we             <= 1'b0;
            dmem_addr           <= '0;
            dmem_wdata          <= '0;
            alu_op_out          <= '0;
            ld_op_out           <= '0;
            wr_mux_sel_out_sync <= 1'b0;
            wb_rd               <= '0;
            wb_we               <= 1'b0;
            wb_valid            <= 1'b0;
            mem_err             <= 1'b0;
        end else begin
            state    <= state_nxt;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_mem) begin
                        // A load+store combination is treated as a store.
                        dmem_addr  <= ex_alu_result;
                        dmem_wdata <= ex_store_data;
                        dmem_we    <= ex_is_store;
                        rd_p0      <= ex_rd;
                        rd_we_p0   <= ex_rd_we;
                        dmem_req   <= 1'b1;
                        cnt        <= '0;
                    end else if (accept) begin
                        alu_op_out          <= ex_alu_result;
                        wr_mux_sel_out_sync <= 1'b0;
                        wb_rd               <= ex_rd;
                        wb_we               <= ex_rd_we;
                        wb_valid            <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // Ack wins over a timeout landing on the same cycle.
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_p0;
                        if (dmem_we) begin
                            wr_mux_sel_out_sync <= 1'b0;
                        end else begin
                            ld_op_out           <= dmem_rdata;
                            wr_mux_sel_out_sync <= 1'b1;
                            wb_we               <= rd_we_p0;
                        end
                    end else if (timeout_hit) begin
                        dmem_req <= 1'b0;
                        mem_err  <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_p0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU forwarding, load/store handshakes,
// ack timeout, ack on the last counter cycle, and reset mid-access.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] ex_alu_result;
    logic [15:0] ex_store_data;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [3:0]  ex_rd;
    logic        ex_rd_we;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic [15:0] alu_op_out;
    logic [15:0] ld_op_out;
    logic        wr_mux_sel_out_sync;
    logic [3:0]  wb_rd;
    logic        wb_we;
    logic        wb_valid;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;
    int req_cnt;

    mem_stage #(.REG_AW(4), .TIMEOUT(16)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ex_valid            (ex_valid),
        .ex_ready            (ex_ready),
        .ex_alu_result       (ex_alu_result),
        .ex_store_data       (ex_store_data),
        .ex_is_load          (ex_is_load),
        .ex_is_store         (ex_is_store),
        .ex_rd               (ex_rd),
        .ex_rd_we            (ex_rd_we),
        .dmem_req            (dmem_req),
        .dmem_we             (dmem_we),
        .dmem_addr           (dmem_addr),
        .dmem_wdata          (dmem_wdata),
        .dmem_ack            (dmem_ack),
        .dmem_rdata          (dmem_rdata),
        .alu_op_out          (alu_op_out),
        .ld_op_out           (ld_op_out),
        .wr_mux_sel_out_sync (wr_mux_sel_out_sync),
        .wb_rd               (wb_rd),
        .wb_we               (wb_we),
        .wb_valid            (wb_valid),
        .mem_err             (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] res, input logic [15:0] sdata,
                         input logic ld, input logic st, input logic [3:0] rd, input logic we);
        ex_valid      = 1'b1;
        ex_alu_result = res;
        ex_store_data = sdata;
        ex_is_load    = ld;
        ex_is_store   = st;
        ex_rd         = rd;
        ex_rd_we      = we;
    endtask

    task automatic idle_ex();
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_ex();
        ex_alu_result = '0; ex_store_data = '0; ex_rd = '0; ex_rd_we = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        #12;
        chk("rst_ex_ready", ex_ready, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_alu_op", alu_op_out, 0);
        chk("rst_mem_err", mem_err, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rel_ex_ready", ex_ready, 1);

        // ALU back-to-back
        issue(16'h1234, 16'h0, 0, 0, 4'd3, 1);
        step();
        chk("alu1_valid", wb_valid, 1);
        chk("alu1_op", alu_op_out, 16'h1234);
        chk("alu1_rd", wb_rd, 3);
        chk("alu1_we", wb_we, 1);
        chk("alu1_sel", wr_mux_sel_out_sync, 0);
        issue(16'hBEEF, 16'h0, 0, 0, 4'd5, 1);
        step();
        chk("alu2_valid", wb_valid, 1);
        chk("alu2_op", alu_op_out, 16'hBEEF);
        chk("alu2_rd", wb_rd, 5);
        chk("alu2_we", wb_we, 1);
        idle_ex();
        step();
        chk("alu_idle_valid", wb_valid, 0);
        chk("alu_idle_we", wb_we, 0);

        // Load, ack sampled on the third cycle of the request
        issue(16'h0040, 16'h0, 1, 0, 4'd7, 1);
        step();
        idle_ex();
        chk("ld_req", dmem_req, 1);
        chk("ld_dmem_we", dmem_we, 0);
        chk("ld_addr", dmem_addr, 16'h0040);
        chk("ld_ex_ready", ex_ready, 0);
        req_cnt = 1;
        step();
        if (dmem_req) req_cnt++;
        chk("ld_ex_ready2", ex_ready, 0);
        step();
        if (dmem_req) req_cnt++;
        dmem_ack = 1'b1; dmem_rdata = 16'hA5A5;
        step();
        dmem_ack = 1'b0; dmem_rdata = 16'h0;
        chk("ld_req_cycles", req_cnt, 3);
        chk("ld_req_drop", dmem_req, 0);
        chk("ld_valid", wb_valid, 1);
        chk("ld_op", ld_op_out, 16'hA5A5);
        chk("ld_sel", wr_mux_sel_out_sync, 1);
        chk("ld_rd", wb_rd, 7);
        chk("ld_we", wb_we, 1);
        chk("ld_ready_back", ex_ready, 1);
        step();
        chk("ld_we_pulse", wb_we, 0);
        chk("ld_valid_pulse", wb_valid, 0);

        // Store, ack after one cycle
        issue(16'h0100, 16'h00FF, 0, 1, 4'd2, 1);
        step();
        idle_ex();
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 16'h0100);
        chk("st_wdata", dmem_wdata, 16'h00FF);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("st_valid", wb_valid, 1);
        chk("st_wb_we", wb_we, 0);
        chk("st_sel", wr_mux_sel_out_sync, 0);
        chk("st_alu_hold", alu_op_out, 16'hBEEF);
        chk("st_ld_hold", ld_op_out, 16'hA5A5);
        chk("st_req_drop", dmem_req, 0);

        // Timeout: load with no ack
        issue(16'h0200, 16'h0, 1, 0, 4'd4, 1);
        step();
        idle_ex();
        req_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            if (dmem_req) chk("to_err_early", mem_err, 0);
            step();
            if (!dmem_req) break;
            req_cnt++;
        end
        chk("to_req_cycles", req_cnt, 16);
        chk("to_mem_err", mem_err, 1);
        chk("to_valid", wb_valid, 1);
        chk("to_we", wb_we, 0);
        chk("to_ld_hold", ld_op_out, 16'hA5A5);
        issue(16'h0055, 16'h0, 0, 0, 4'd1, 1);
        step();
        idle_ex();
        chk("to_alu_valid", wb_valid, 1);
        chk("to_alu_op", alu_op_out, 16'h0055);
        chk("to_err_sticky", mem_err, 1);

        // Clear mem_err, then ack exactly on counter == TIMEOUT-1
        rst_n = 1'b0;
        #1;
        chk("rst2_err", mem_err, 0);
        rst_n = 1'b1;
        issue(16'h0300, 16'h0, 1, 0, 4'd6, 1);
        step();
        idle_ex();
        for (int i = 0; i < 15; i++) step();
        chk("last_req_still", dmem_req, 1);
        dmem_ack = 1'b1; dmem_rdata = 16'h5A5A;
        step();
        dmem_ack = 1'b0; dmem_rdata = 16'h0;
        chk("last_valid", wb_valid, 1);
        chk("last_we", wb_we, 1);
        chk("last_ld", ld_op_out, 16'h5A5A);
        chk("last_sel", wr_mux_sel_out_sync, 1);
        chk("last_err", mem_err, 0);
        step();

        // Reset in the middle of WAIT_ACK
        issue(16'h0400, 16'h0, 1, 0, 4'd9, 1);
        step();
        idle_ex();
        chk("mid_req", dmem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_req_drop", dmem_req, 0);
        chk("mid_addr", dmem_addr, 0);
        chk("mid_ld", ld_op_out, 0);
        chk("mid_ready", ex_ready, 0);
        step();
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 16'hFFFF;
        step();
        dmem_ack = 1'b0;
        chk("stray_valid", wb_valid, 0);
        chk("stray_ld", ld_op_out, 0);
        chk("stray_ready", ex_ready, 1);
        step();
        chk("stray_valid2", wb_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
